modn_updn_ctr: RTL
==================

MODN_UPDN_CTR -- requirements
Module: modn_updn_ctr

Interface
REQ-001 Parameter N, default 10, counter modulus (count range 0..N-1).
REQ-002 Parameter WIDTH, default 4, output width in bits.
REQ-003 Parameter INIT, default 0, value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous and active-low.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value captured when load is high.
REQ-010 out  output  WIDTH  registered count value.
REQ-011 tc  output  1  combinational terminal count; feeds cascading.
REQ-012 wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap (or saturation hit) occurs.

Function
REQ-013 Priority per edge: load > en > hold.
REQ-014 With load=1, out SHALL take load_val next edge, or N-1 if load_val >= N (clamp); wrap SHALL be 0.
REQ-015 With load=0, en=1, up=1: out SHALL increment by 1; at out=N-1 it SHALL become 0.
REQ-016 With load=0, en=1, up=0: out SHALL decrement by 1; at out=0 it SHALL become N-1.
REQ-017 With load=0 and en=0, out and all state SHALL hold.
REQ-018 tc SHALL equal en & ~load & ((up & out==N-1) | (~up & out==0)).
REQ-019 wrap SHALL be 1 exactly in the cycle after an edge where tc was 1; otherwise 0.
REQ-020 Latency: one clock from input to out; tc has zero latency.
REQ-021 Direction changes SHALL take effect on the same edge as the change, with no idle cycle.
REQ-022 Arithmetic SHALL use WIDTH bits with no intermediate overflow; out SHALL never exceed N-1.

Reset
REQ-023 rstn low SHALL immediately set out=INIT and wrap=0, independent of clk, including mid-count or mid-load.
REQ-024 The first rising edge after rstn deasserts SHALL operate normally; no extra synchronising cycle.

Configuration
REQ-025 Macro MODN_UPDN_CTR_SAT_EN compiles in an extra input port sat (1 bit).
REQ-026 With the macro and sat=1, the counter SHALL stop at N-1 (up) or 0 (down) instead of wrapping.
REQ-027 With the macro and sat=1, tc and wrap SHALL still assert at the boundary as defined in REQ-018/REQ-019.
REQ-028 Without the macro, sat is absent and behaviour is wrap-only.

Structure
REQ-029 Package modn_pkg SHALL hold typedef dir_t (DN=0, UP=1) and constant MODN_DEFAULT_N=10.
REQ-030 Next-value logic SHALL live in one combinational sub-module modn_next_calc, which takes out, up, N, and sat and produces next value and tc.
REQ-031 Elaboration SHALL fail if N<2, N>2**WIDTH, or INIT>=N.

Verification (N=10, WIDTH=4, INIT=0)
REQ-032 Reset release, en=1, up=1, 12 edges -> out 1..9, 0, 1, 2; tc high while out=9; wrap pulses one cycle after 9->0.
REQ-033 From out=0, en=1, up=0, 2 edges -> out 9, then 8; wrap pulses once.
REQ-034 load=1, load_val=4'hC with en=1 -> out=9 (clamp); wrap=0; tc=0 during the load cycle.
REQ-035 Count to out=5, drop rstn between edges -> out=0 immediately, wrap=0; release -> counting resumes 1, 2, ...
REQ-036 en=0 for 5 edges at out=7 -> out stays 7 and tc=0; toggle up at out=3 -> next value 2.
REQ-037 With MODN_UPDN_CTR_SAT_EN, sat=1, up=1 from out=8, 3 edges -> out 9, 9, 9; tc stays 1 at out=9 and wrap pulses each cycle.

Source files
------------

// File: rtl/modn_pkg.sv
// modn_pkg: shared direction type and default modulus for the mod-N up/down counter.
package modn_pkg;
  typedef enum logic {DN = 1'b0, UP = 1'b1} dir_t;
  localparam int MODN_DEFAULT_N = 10;
endpackage

// File: rtl/modn_next_calc.sv
// modn_next_calc: combinational next-count and terminal-count logic for a mod-N up/down counter.
module modn_next_calc
  import modn_pkg::*;
#(
  parameter int N     = MODN_DEFAULT_N,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic             sat,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  dir_t             dir;
  logic             at_end;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] ld;
  always_comb begin
    dir    = dir_t'(up);
    at_end = (dir == UP) ? (cur == MAX) : (cur == '0);
    step   = (dir == UP) ? ((cur == MAX) ? (sat ? MAX : '0) : cur + ONE)
                         : ((cur == '0)  ? (sat ? '0 : MAX) : cur - ONE);
    // out-of-range loads clamp to the top of the count range
    ld     = (32'(load_val) >= N) ? MAX : load_val;
    nxt    = load ? ld : (en ? step : cur);
    tc     = en & ~load & at_end;
  end
endmodule

// File: rtl/modn_updn_ctr.sv
// modn_updn_ctr: mod-N up/down counter with load, terminal count and wrap pulse.
// Define MODN_UPDN_CTR_SAT_EN to add a sat input that saturates instead of wrapping.
module modn_updn_ctr
  import modn_pkg::*;
#(
  parameter int N     = MODN_DEFAULT_N,
  parameter int WIDTH = 4,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODN_UPDN_CTR_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);
  if (N < 2 || N > 2 ** WIDTH || INIT >= N) begin : g_bad_params
    $error("modn_updn_ctr: illegal N/WIDTH/INIT combination");
  end
  logic [WIDTH-1:0] out_q, out_d, nxt;
  logic             wrap_q, wrap_d, sat_i;
`ifdef MODN_UPDN_CTR_SAT_EN
  assign sat_i = sat;
`else
  assign sat_i = 1'b0;
`endif
  modn_next_calc #(.N(N), .WIDTH(WIDTH)) u_next (
    .cur     (out_q),
    .up      (up),
    .en      (en),
    .load    (load),
    .sat     (sat_i),
    .load_val(load_val),
    .nxt     (nxt),
    .tc      (tc)
  );
  always_comb begin
    out_d  = nxt;
    wrap_d = tc;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= WIDTH'(INIT);
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end
  assign out  = out_q;
  assign wrap = wrap_q;
endmodule
